mesi_system_top: RTL and testbench

- Self-contained 4-core MESI coherence demonstrator.
- Contains 4 private direct-mapped single-word caches, one serialized snooping coherence controller, a 256-word main memory and an internal fixed operation script (ROM).
- Only clock and reset are needed to run. Status outputs exist for monitoring and may be left unconnected.

---
 rtl/mesi_system_top.sv | 199 +++++++++++++++++++
 tb/tb_mesi_system_top.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mesi_system_top.sv
// mesi_system_top: self-contained 4-core MESI coherence demonstrator.
// Four private direct-mapped single-word caches share one serialized snooping
// bus in front of a 256-word memory. A fixed script in ROM drives one
// operation at a time; the status outputs expose the operation in flight.
module mesi_system_top #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_LINES  = 4,
  parameter int SCRIPT_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        op_active,
  output logic [1:0]  op_core,
  output logic [7:0]  op_addr,
  output logic [1:0]  op_state,
  output logic [31:0] rd_data,
  output logic        done
);

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;
  localparam logic [3:0] LEN_C = 4'(SCRIPT_LEN);
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_LOOKUP, S_WB, S_SNOOP, S_UPDATE, S_COMPLETE, S_DONE
  } fsm_t;

  fsm_t state_r, next_s;

  // Cache arrays, indexed [core][line].
  logic [1:0]        st_r  [NUM_CORES][NUM_LINES];
  logic [5:0]        tag_r [NUM_CORES][NUM_LINES];
  logic [DATA_W-1:0] dat_r [NUM_CORES][NUM_LINES];
  logic [DATA_W-1:0] mem_r [MEM_DEPTH];

  logic [3:0]        ptr_r;
  logic [1:0]        cur_core_r;
  logic              cur_rw_r;      // 1 = write
  logic [7:0]        cur_addr_r;
  logic [DATA_W-1:0] cur_wdata_r;
  logic              shared_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              op_active_r;
  logic              done_r;

  logic [1:0]        cur_idx_s;
  logic [5:0]        cur_tag_s;
  logic [1:0]        req_st_s;
  logic              hit_s;
  logic              victim_m_s;
  logic [NUM_CORES-1:0] other_vec_s;
  logic [42:0]       rom_s;

  // Script ROM entry: {core[1:0], rw, addr[7:0], wdata[31:0]}.
  function automatic logic [42:0] rom_entry(input logic [2:0] p);
    case (p)
      3'd0:    rom_entry = {2'd0, 1'b0, 8'h10, 32'h0000_0000};
      3'd1:    rom_entry = {2'd1, 1'b0, 8'h10, 32'h0000_0000};
      3'd2:    rom_entry = {2'd2, 1'b1, 8'h10, 32'hA5A5_0002};
      3'd3:    rom_entry = {2'd0, 1'b0, 8'h10, 32'h0000_0000};
      3'd4:    rom_entry = {2'd3, 1'b1, 8'h24, 32'h0000_C3C3};
      3'd5:    rom_entry = {2'd3, 1'b0, 8'h24, 32'h0000_0000};
      3'd6:    rom_entry = {2'd3, 1'b0, 8'h34, 32'h0000_0000};
      3'd7:    rom_entry = {2'd1, 1'b1, 8'h14, 32'h1111_0014};
      default: rom_entry = 43'd0;
    endcase
  endfunction

  assign rom_s      = rom_entry(ptr_r[2:0]);
  assign cur_idx_s  = cur_addr_r[1:0];
  assign cur_tag_s  = cur_addr_r[7:2];
  assign req_st_s   = st_r[cur_core_r][cur_idx_s];
  assign hit_s      = (req_st_s != ST_I) && (tag_r[cur_core_r][cur_idx_s] == cur_tag_s);
  assign victim_m_s = (req_st_s == ST_M) && !hit_s;

  // Flag every other cache currently holding a valid copy of the current address.
  always_comb begin
    other_vec_s = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if ((c[1:0] != cur_core_r) && (st_r[c][cur_idx_s] != ST_I) &&
          (tag_r[c][cur_idx_s] == cur_tag_s)) begin
        other_vec_s[c] = 1'b1;
      end else begin
        other_vec_s[c] = 1'b0;
      end
    end
  end

  // Next-state logic of the operation sequencer.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE:     next_s = (ptr_r < LEN_C) ? S_ISSUE : S_DONE;
      S_ISSUE:    next_s = S_LOOKUP;
      S_LOOKUP:   next_s = victim_m_s ? S_WB : S_SNOOP;
      S_WB:       next_s = S_SNOOP;
      S_SNOOP:    next_s = S_UPDATE;
      S_UPDATE:   next_s = S_COMPLETE;
      S_COMPLETE: next_s = S_IDLE;
      S_DONE:     next_s = S_DONE;
      default:    next_s = S_IDLE;
    endcase
  end

  // State register plus status flags derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      op_active_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= next_s;
      op_active_r <= (next_s == S_ISSUE) || (next_s == S_LOOKUP) || (next_s == S_WB) ||
                     (next_s == S_SNOOP) || (next_s == S_UPDATE);
      done_r      <= (next_s == S_DONE);
    end
  end

  // Datapath: script fetch, victim writeback, snoop actions, line update, completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        for (int l = 0; l < NUM_LINES; l++) begin
          st_r[c][l]  <= ST_I;
          tag_r[c][l] <= 6'd0;
          dat_r[c][l] <= 32'd0;
        end
      end
      for (int a = 0; a < MEM_DEPTH; a++) begin
        mem_r[a] <= {24'h0, a[7:0]};
      end
      ptr_r       <= 4'd0;
      cur_core_r  <= 2'd0;
      cur_rw_r    <= 1'b0;
      cur_addr_r  <= 8'd0;
      cur_wdata_r <= 32'd0;
      shared_r    <= 1'b0;
      rd_data_r   <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (ptr_r < LEN_C) begin
            cur_core_r  <= rom_s[42:41];
            cur_rw_r    <= rom_s[40];
            cur_addr_r  <= rom_s[39:32];
            cur_wdata_r <= rom_s[31:0];
          end
        end
        S_WB: begin
          mem_r[{tag_r[cur_core_r][cur_idx_s], cur_idx_s}] <= dat_r[cur_core_r][cur_idx_s];
        end
        S_SNOOP: begin
          shared_r <= |other_vec_s;
          for (int c = 0; c < NUM_CORES; c++) begin
            if (other_vec_s[c]) begin
              // At most one M copy exists, so at most one memory write here.
              if (st_r[c][cur_idx_s] == ST_M) begin
                mem_r[cur_addr_r] <= dat_r[c][cur_idx_s];
              end
              st_r[c][cur_idx_s] <= cur_rw_r ? ST_I : ST_S;
            end
          end
        end
        S_UPDATE: begin
          if (cur_rw_r) begin
            dat_r[cur_core_r][cur_idx_s] <= cur_wdata_r;
            tag_r[cur_core_r][cur_idx_s] <= cur_tag_s;
            st_r[cur_core_r][cur_idx_s]  <= ST_M;
          end else if (!hit_s) begin
            dat_r[cur_core_r][cur_idx_s] <= mem_r[cur_addr_r];
            tag_r[cur_core_r][cur_idx_s] <= cur_tag_s;
            st_r[cur_core_r][cur_idx_s]  <= shared_r ? ST_S : ST_E;
          end
        end
        S_COMPLETE: begin
          if (!cur_rw_r) begin
            rd_data_r <= dat_r[cur_core_r][cur_idx_s];
          end
          ptr_r <= ptr_r + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign op_active = op_active_r;
  assign op_core   = cur_core_r;
  assign op_addr   = cur_addr_r;
  assign op_state  = req_st_s;
  assign rd_data   = rd_data_r;
  assign done      = done_r;

endmodule

// File: tb/tb_mesi_system_top.sv
// Testbench for mesi_system_top: runs the built-in script against a
// procedural MESI reference model, with randomized reset lengths and a
// randomly placed mid-operation reset.
module tb_mesi_system_top;

  logic        clk;
  logic        reset;
  logic        op_active;
  logic [1:0]  op_core;
  logic [7:0]  op_addr;
  logic [1:0]  op_state;
  logic [31:0] rd_data;
  logic        done;

  int total = 0;
  int bad   = 0;

  // Reference model state: state 0=I 1=S 2=E 3=M.
  int          mst  [4][4];
  int          mtag [4][4];
  logic [31:0] mdat [4][4];
  logic [31:0] mmem [256];
  logic [31:0] mrd;

  // Script as the bench knows it.
  int          sc_core [8] = '{0, 1, 2, 0, 3, 3, 3, 1};
  int          sc_rw   [8] = '{0, 0, 1, 0, 1, 0, 0, 1};
  int          sc_addr [8] = '{'h10, 'h10, 'h10, 'h10, 'h24, 'h24, 'h34, 'h14};
  logic [31:0] sc_wd   [8] = '{32'h0, 32'h0, 32'hA5A5_0002, 32'h0,
                               32'h0000_C3C3, 32'h0, 32'h0, 32'h1111_0014};

  mesi_system_top dut (
    .clk(clk), .reset(reset), .op_active(op_active), .op_core(op_core),
    .op_addr(op_addr), .op_state(op_state), .rd_data(rd_data), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic model_reset();
    for (int c = 0; c < 4; c++)
      for (int l = 0; l < 4; l++) begin
        mst[c][l] = 0; mtag[c][l] = 0; mdat[c][l] = 32'h0;
      end
    for (int a = 0; a < 256; a++) mmem[a] = a;
    mrd = 32'h0;
  endtask

  // Apply one operation to the model; report writeback and before/after state.
  task automatic model_step(input int core, input int rw, input int addr,
                            input logic [31:0] wd, output int wb,
                            output int pre, output int post);
    int idx, tag, hit, shared;
    idx = addr % 4;
    tag = addr / 4;
    pre = mst[core][idx];
    hit = (pre != 0) && (mtag[core][idx] == tag);
    wb = 0;
    if (!hit && pre == 3) begin
      mmem[mtag[core][idx] * 4 + idx] = mdat[core][idx];
      wb = 1;
    end
    shared = 0;
    for (int c = 0; c < 4; c++) begin
      if (c != core && mst[c][idx] != 0 && mtag[c][idx] == tag) begin
        shared = 1;
        if (mst[c][idx] == 3) mmem[addr] = mdat[c][idx];
        mst[c][idx] = rw ? 0 : 1;
      end
    end
    if (rw) begin
      mdat[core][idx] = wd; mtag[core][idx] = tag; mst[core][idx] = 3;
    end else begin
      if (!hit) begin
        mdat[core][idx] = mmem[addr];
        mtag[core][idx] = tag;
        mst[core][idx]  = shared ? 1 : 2;
      end
      mrd = mdat[core][idx];
    end
    post = mst[core][idx];
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    n = $urandom_range(2, 5);
    repeat (n) @(negedge clk);
    model_reset();
    total++; if (op_active !== 1'b0) begin bad++; $display("FAIL reset_op_active: got %b want 0", op_active); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    total++; if (op_core !== 2'd0 || op_addr !== 8'h0) begin bad++; $display("FAIL reset_op: core=%0d addr=%h want 0/00", op_core, op_addr); end
    total++; if (op_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", op_state); end
    reset = 1'b1;
    n = 1;
    @(negedge clk);
    while (op_active !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++; if (n > 2) begin bad++; $display("FAIL reset_first_op: op_active after %0d cycles want <=2", n); end
  endtask

  // Run the first n script operations and check each against the model.
  task automatic test_script(input int n);
    int cnt, wb, pre, post, act;
    for (int i = 0; i < n; i++) begin
      cnt = 0;
      while (op_active !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
      total++;
      if (op_active !== 1'b1) begin
        bad++; $display("FAIL op%0d_start: op_active=%b want 1 within 20 cycles", i, op_active);
        return;
      end
      model_step(sc_core[i], sc_rw[i], sc_addr[i], sc_wd[i], wb, pre, post);
      total++; if (op_core !== 2'(sc_core[i])) begin bad++; $display("FAIL op%0d_core: got %0d want %0d", i, op_core, sc_core[i]); end
      total++; if (op_addr !== 8'(sc_addr[i])) begin bad++; $display("FAIL op%0d_addr: got %h want %h", i, op_addr, sc_addr[i]); end
      total++; if (op_state !== 2'(pre)) begin bad++; $display("FAIL op%0d_pre_state: got %0d want %0d", i, op_state, pre); end
      act = 0;
      while (op_active === 1'b1 && act < 20) begin act++; @(negedge clk); end
      total++; if (act != (wb ? 5 : 4)) begin bad++; $display("FAIL op%0d_latency: got %0d want %0d", i, act, wb ? 5 : 4); end
      total++; if (op_state !== 2'(post)) begin bad++; $display("FAIL op%0d_post_state: got %0d want %0d", i, op_state, post); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL op%0d_done_early: got %b want 0", i, done); end
      @(negedge clk);
      total++; if (rd_data !== mrd) begin bad++; $display("FAIL op%0d_rd_data: got %h want %h", i, rd_data, mrd); end
    end
  endtask

  task automatic test_done();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      total++; if (done !== 1'b1 || op_active !== 1'b0) begin bad++; $display("FAIL done_hold%0d: done=%b op_active=%b want 1/0", k, done, op_active); end
      @(negedge clk);
    end
    total++; if (rd_data !== mrd) begin bad++; $display("FAIL done_rd_data: got %h want %h", rd_data, mrd); end
  endtask

  // Reset a random number of operations into the script, in the middle of an op.
  task automatic test_abort_reset();
    int k, d, cnt;
    test_reset();
    k = $urandom_range(1, 7);
    test_script(k);
    cnt = 0;
    while (op_active !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    total++; if (op_active !== 1'b1) begin bad++; $display("FAIL abort_start: op_active=%b want 1", op_active); end
    d = $urandom_range(0, 2);
    repeat (d) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (op_active !== 1'b0) begin bad++; $display("FAIL abort_op_active: got %b want 0", op_active); end
    total++; if (op_state !== 2'd0) begin bad++; $display("FAIL abort_state: got %0d want 0", op_state); end
    total++; if (rd_data !== 32'h0 || done !== 1'b0) begin bad++; $display("FAIL abort_outputs: rd=%h done=%b want 0/0", rd_data, done); end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_script(8);
    test_done();
    test_abort_reset();
    test_reset();
    test_script(8);
    test_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
